// File: rtl/lfsr_byte_packer_pkg.sv
// Shared definitions for the LFSR keystream byte packer.
//   LFSR_W      : LFSR register width / default packed word width
//   LFSR_CNT_W  : width of a bit count able to hold 0..LFSR_W
//   word_entry_t: one FIFO entry, data plus its valid-bit count
package lfsr_pkg;

    localparam int LFSR_W = 8;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int LFSR_CNT_W = cnt_width(LFSR_W);

    typedef struct packed {
        logic [LFSR_W-1:0]     data;
        logic [LFSR_CNT_W-1:0] bits;
    } word_entry_t;

endpackage

// File: rtl/lfsr_byte_packer_if.sv
// Word stream leaving the packer (valid/ready).
//   word_out   : head-of-FIFO word
//   word_bits  : number of valid (MSB-aligned) bits in word_out
//   word_valid : a word is available
//   word_ready : consumer takes the head this cycle
// master = packer side, slave = consumer side.
interface lfsr_byte_packer_if #(
    parameter int W = lfsr_pkg::LFSR_W
);
    localparam int BW = $clog2(W + 1);

    logic [W-1:0]  word_out;
    logic [BW-1:0] word_bits;
    logic          word_valid;
    logic          word_ready;

    modport master (output word_out, word_bits, word_valid, input word_ready);
    modport slave  (input word_out, word_bits, word_valid, output word_ready);
endinterface

// File: rtl/lfsr_word_fifo.sv
// Synchronous DEPTH-entry FIFO holding packed words.
//   clk, rst  : clock, synchronous active-high reset (storage cleared)
//   push      : write push_data; ignored when full at start of cycle
//   push_data : entry to store
//   pop       : drop the head; ignored when empty
//   head      : current head entry (register contents)
//   full/empty: occupancy flags
module lfsr_word_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (count == (AW+1)'(DEPTH));
        empty   = (count == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        head    = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/lfsr_byte_packer.sv
// Packs the serial LFSR keystream into W-bit words, MSB first, and queues
// them in a small FIFO. bit_ready gates the LFSR enable upstream so no bit
// is produced that cannot be stored. flush emits a partial word,
// left-aligned, with its valid-bit count.
//   clk, rst      : clock, synchronous active-high reset
//   bit_in        : serial keystream bit
//   bit_valid     : bit_in valid (LFSR enable)
//   bit_ready     : packer can take a bit this cycle
//   flush         : emit current partial word
//   word_if       : outgoing word stream (master)
//   words_emitted : words pushed into the FIFO, wraps modulo 2^CW
module lfsr_byte_packer
    import lfsr_pkg::*;
#(
    parameter int W     = LFSR_W,
    parameter int DEPTH = 2,
    parameter int CW    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bit_in,
    input  logic                       bit_valid,
    output logic                       bit_ready,
    input  logic                       flush,
    lfsr_byte_packer_if.master         word_if,
    output logic [CW-1:0]              words_emitted
);
    localparam int BW = cnt_width(W);
    localparam logic [BW-1:0] LAST = BW'(W - 1);

    typedef struct packed {
        logic [W-1:0]  data;
        logic [BW-1:0] bits;
    } entry_t;

    logic [W-1:0]  acc;
    logic [W-1:0]  acc_nxt;
    logic [BW-1:0] bit_cnt;
    logic [BW-1:0] cnt_nxt;
    logic          flush_pending;
    logic          fifo_full;
    logic          fifo_empty;
    logic          accept;
    logic          last_bit;
    logic          flush_now;
    logic          push;
    entry_t        push_entry;
    entry_t        head;

    always_comb begin
        bit_ready = !rst && !flush_pending && !(fifo_full && bit_cnt == LAST);
        accept    = bit_valid && bit_ready;
        last_bit  = accept && (bit_cnt == LAST);

        acc_nxt = acc;
        cnt_nxt = bit_cnt;
        if (accept) begin
            acc_nxt = acc | (W'(bit_in) << (LAST - bit_cnt));
            cnt_nxt = bit_cnt + BW'(1);
        end

        // A flush counts the bit accepted this cycle; a completing bit wins
        // and the flush then has nothing left to emit.
        flush_now = flush && !flush_pending && !last_bit && (cnt_nxt != '0);

        // cnt_nxt equals W on the completing bit, so it is the count in
        // every push case (full word, immediate flush, deferred flush).
        push = last_bit || (flush_pending && !fifo_full) || (flush_now && !fifo_full);
        push_entry.data = acc_nxt;
        push_entry.bits = cnt_nxt;

        word_if.word_valid = !fifo_empty;
        word_if.word_out   = head.data;
        word_if.word_bits  = head.bits;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc           <= '0;
            bit_cnt       <= '0;
            flush_pending <= 1'b0;
            words_emitted <= '0;
        end else if (push) begin
            acc           <= '0;
            bit_cnt       <= '0;
            flush_pending <= 1'b0;
            words_emitted <= words_emitted + CW'(1);
        end else begin
            acc     <= acc_nxt;
            bit_cnt <= cnt_nxt;
            if (flush_now) begin
                flush_pending <= 1'b1;
            end
        end
    end

    lfsr_word_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (word_if.word_valid && word_if.word_ready),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );
endmodule

// File: tb/tb_lfsr_byte_packer.sv
// Randomised and directed bench for lfsr_byte_packer against a queue-based
// reference model of the packing and FIFO rules.
module tb_lfsr_byte_packer;
    import lfsr_pkg::*;

    localparam int W     = 8;
    localparam int DEPTH = 2;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          bit_in;
    logic          bit_valid;
    logic          bit_ready;
    logic          flush;
    logic [CW-1:0] words_emitted;

    lfsr_byte_packer_if #(.W(W)) wif ();

    lfsr_byte_packer #(
        .W     (W),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bit_in        (bit_in),
        .bit_valid     (bit_valid),
        .bit_ready     (bit_ready),
        .flush         (flush),
        .word_if       (wif),
        .words_emitted (words_emitted)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    word_entry_t m_q[$];
    bit          m_bits[$];
    bit          m_pend;
    int unsigned m_emit;
    bit          m_accepted;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pack_bits();
        logic [W-1:0] v = '0;
        foreach (m_bits[i]) begin
            if (m_bits[i]) v = v | (8'h80 >> i);
        end
        return v;
    endfunction

    // One clock cycle: drive, check bit_ready, advance model, check outputs.
    task automatic step(input bit r, input bit bv, input bit b, input bit fl, input bit wr);
        bit          exp_ready;
        bit          full_start;
        bit          pop;
        bit          push;
        word_entry_t e;
        rst = r; bit_valid = bv; bit_in = b; flush = fl; wif.word_ready = wr;
        #1;
        exp_ready = !r && !m_pend && !(m_q.size() == DEPTH && m_bits.size() == W - 1);
        check_eq("bit_ready", 32'(bit_ready), 32'(exp_ready));
        m_accepted = bv && exp_ready;
        if (r) begin
            m_q.delete();
            m_bits.delete();
            m_pend = 1'b0;
            m_emit = 0;
        end else begin
            full_start = (m_q.size() == DEPTH);
            pop        = (m_q.size() > 0) && wr;
            push       = 1'b0;
            if (m_accepted) m_bits.push_back(b);
            if (m_bits.size() == W) push = 1'b1;
            else if (m_pend) begin
                if (!full_start) push = 1'b1;
            end else if (fl && m_bits.size() > 0) begin
                if (full_start) m_pend = 1'b1;
                else push = 1'b1;
            end
            if (pop) void'(m_q.pop_front());
            if (push) begin
                e.data = pack_bits();
                e.bits = LFSR_CNT_W'(m_bits.size());
                m_q.push_back(e);
                m_bits.delete();
                m_pend = 1'b0;
                m_emit = (m_emit + 1) % 65536;
            end
        end
        @(posedge clk);
        #1;
        check_eq("word_valid", 32'(wif.word_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check_eq("word_out", 32'(wif.word_out), 32'(m_q[0].data));
            check_eq("word_bits", 32'(wif.word_bits), 32'(m_q[0].bits));
        end
        check_eq("words_emitted", 32'(words_emitted), m_emit);
    endtask

    task automatic send_bit(input bit b, input bit wr);
        for (int t = 0; t < 20; t++) begin
            step(1'b0, 1'b1, b, 1'b0, wr);
            if (m_accepted) return;
        end
        check_eq("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic feed_byte(input logic [7:0] v, input bit wr);
        for (int i = 7; i >= 0; i--) send_bit(v[i], wr);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] emit_before;
        int unsigned   pv;
        int unsigned   pf;
        int unsigned   pr;

        rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; flush = 1'b0; wif.word_ready = 1'b1;
        m_pend = 1'b0; m_emit = 0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check_eq("rst_word_out", 32'(wif.word_out), 32'd0);
        check_eq("rst_word_bits", 32'(wif.word_bits), 32'd0);

        // Full word B2
        feed_byte(8'hB2, 1'b1);
        check_eq("b2_out", 32'(wif.word_out), 32'h0B2);
        check_eq("b2_bits", 32'(wif.word_bits), 32'd8);
        check_eq("b2_emit", 32'(words_emitted), 32'd1);

        // Partial flush C0, then no-op flush at bit_cnt 0
        send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("c0_out", 32'(wif.word_out), 32'h0C0);
        check_eq("c0_bits", 32'(wif.word_bits), 32'd3);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("noop_flush_emit", 32'(words_emitted), 32'd2);
        drain();

        // FIFO full back-pressure on the last bit
        feed_byte(8'hFF, 1'b0);
        feed_byte(8'h00, 1'b0);
        for (int i = 0; i < 7; i++) send_bit(1'(~i & 1), 1'b0);
        bit_valid = 1'b0;
        #1;
        check_eq("full_ready_low", 32'(bit_ready), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        check_eq("after_pop_head", 32'(wif.word_out), 32'h000);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        drain();

        // Flush coincident with the final bit
        for (int i = 0; i < 7; i++) send_bit(1'((8'hA5 >> (7 - i)) & 8'h01), 1'b1);
        emit_before = words_emitted;
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("a5_single_push", 32'(words_emitted), 32'(emit_before) + 32'd1);
        check_eq("a5_bits", 32'(wif.word_bits), 32'd8);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        // Deferred flush while full
        feed_byte(8'hFF, 1'b0);
        feed_byte(8'h00, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("pend_ready_low", 32'(bit_ready), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("pend_ready_back", 32'(bit_ready), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("a0_out", 32'(wif.word_out), 32'h0A0);
        check_eq("a0_bits", 32'(wif.word_bits), 32'd4);
        drain();

        // Reset mid-word with a word queued
        feed_byte(8'h3C, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("rst_valid", 32'(wif.word_valid), 32'd0);
        check_eq("rst_emit", 32'(words_emitted), 32'd0);
        feed_byte(8'h96, 1'b1);
        check_eq("fresh_word", 32'(wif.word_out), 32'h096);

        // Randomised traffic with shifting densities
        pv = 50; pf = 5; pr = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) begin
                pv = $urandom_range(10, 100);
                pf = $urandom_range(0, 30);
                pr = $urandom_range(5, 100);
            end
            step(1'($urandom_range(0, 299) == 0),
                 1'($urandom_range(0, 99) < pv),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 99) < pf),
                 1'($urandom_range(0, 99) < pr));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
